// File: rtl/bcd_convert_arbiter.sv
// ---------------------------------------------------------------------------
// bcd_convert_arbiter
//   One sequential double-dabble (shift-add-3) binary-to-BCD engine shared by
//   NREQ requesters. In IDLE a winner is picked and its operand is captured.
//   The engine then runs WIDTH shift cycles. The packed BCD result is returned
//   with a one-cycle done pulse, tagged by requester index.
//
//   Optional feature macro: ARB_RR_EN
//     defined   -> round-robin arbitration (search starts at rr_ptr+1)
//     undefined -> fixed priority, lowest index wins (no rr_ptr state)
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   req      in   [NREQ]        req[i] high = requester i wants a conversion
//   bin_in   in   [NREQ*WIDTH]  operand i at bits [i*WIDTH +: WIDTH]
//   gnt      out  [NREQ]        one-hot, one cycle: operand i captured
//   busy     out                engine converting
//   done     out                one-cycle pulse: bcd_out/done_id valid
//   done_id  out  [clog2(NREQ)] requester index of the result on bcd_out
//   bcd_out  out  [4*DIGITS]    packed BCD, MS digit on top; held until next done
// ---------------------------------------------------------------------------
module bcd_convert_arbiter #(
   parameter int NREQ   = 3,
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ*WIDTH-1:0]     bin_in,
   output logic [NREQ-1:0]           gnt,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(NREQ)-1:0]   done_id,
   output logic [4*DIGITS-1:0]       bcd_out
);

   localparam int IDX_W = $clog2(NREQ);
   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int ACC_W = 4 * DIGITS;

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e             state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [WIDTH-1:0]   shreg_q,   shreg_d;
   logic [ACC_W-1:0]   acc_q,     acc_d;
   logic [IDX_W-1:0]   id_q,      id_d;
   logic [NREQ-1:0]    gnt_q,     gnt_d;
   logic               done_q,    done_d;
   logic [IDX_W-1:0]   done_id_q, done_id_d;
   logic [ACC_W-1:0]   bcd_q,     bcd_d;

   logic               win_found;
   logic [IDX_W-1:0]   win_idx;
   logic [ACC_W-1:0]   acc_adj;
   logic [ACC_W-1:0]   acc_shift;

   // ---------------- arbiter ----------------
`ifdef ARB_RR_EN
   logic [IDX_W-1:0]   rr_ptr_q,  rr_ptr_d;
   logic [IDX_W-1:0]   cand;

   // Search starts one past the last winner, wrapping modulo NREQ.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves it unassigned and no latch is inferred.
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDX_W'((int'(rr_ptr_q) + 1 + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end
`else
   // Fixed priority: scan from the top so the lowest requesting index wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end
`endif

   // ---------------- shift-add-3 datapath ----------------
   // Digits >= 5 get +3 before the shift so that the doubling carries into
   // the next digit exactly when the decimal digit would overflow.
   always_comb begin
      acc_adj = acc_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
   end

   assign acc_shift = {acc_adj[ACC_W-2:0], shreg_q[WIDTH-1]};

   // ---------------- FSM next state / outputs ----------------
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shreg_d   = shreg_q;
      acc_d     = acc_q;
      id_d      = id_q;
      gnt_d     = '0;
      done_d    = 1'b0;
      done_id_d = done_id_q;
      bcd_d     = bcd_q;
`ifdef ARB_RR_EN
      rr_ptr_d  = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            if (win_found) begin
               shreg_d        = bin_in[win_idx*WIDTH +: WIDTH];
               acc_d          = '0;
               cnt_d          = '0;
               id_d           = win_idx;
               gnt_d[win_idx] = 1'b1;
               state_d        = SHIFT;
`ifdef ARB_RR_EN
               rr_ptr_d       = win_idx;
`endif
            end
         end
         SHIFT: begin
            acc_d   = acc_shift;
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               bcd_d     = acc_shift;
               done_d    = 1'b1;
               done_id_d = id_q;
               cnt_d     = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         shreg_q   <= '0;
         acc_q     <= '0;
         id_q      <= '0;
         gnt_q     <= '0;
         done_q    <= 1'b0;
         done_id_q <= '0;
         bcd_q     <= '0;
`ifdef ARB_RR_EN
         rr_ptr_q  <= IDX_W'(NREQ - 1);
`endif
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shreg_q   <= shreg_d;
         acc_q     <= acc_d;
         id_q      <= id_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
         done_id_q <= done_id_d;
         bcd_q     <= bcd_d;
`ifdef ARB_RR_EN
         rr_ptr_q  <= rr_ptr_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign busy    = (state_q == SHIFT);
   assign done    = done_q;
   assign done_id = done_id_q;
   assign bcd_out = bcd_q;

endmodule
